// File: rtl/seg7_pkg.sv
// Shared constants for the segment read-back path: active-low glyphs (bit0=a..bit6=g)
// and the receiver FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Alternate drawings some display drivers use for 7 (with f) and 9 (without d).
  localparam logic [6:0] SEG_ALT_7 = 7'h58;
  localparam logic [6:0] SEG_ALT_9 = 7'h18;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    EMIT
  } state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph-to-nibble decoder for one digit.
// Define SEG7_ALT_GLYPHS_EN to also accept the alternate 7 and 9 drawings.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       legal
);

  always_comb begin
    nibble = 4'h0;
    legal  = 1'b1;
    case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
`ifdef SEG7_ALT_GLYPHS_EN
      SEG_ALT_7: nibble = 4'h7;
      SEG_ALT_9: nibble = 4'h9;
`else
      SEG_ALT_7: legal = 1'b0;
      SEG_ALT_9: legal = 1'b0;
`endif
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_pattern_rx.sv
// Segment-bus receiver: synchronizes two active-low digit patterns, waits for them to hold
// steady, decodes to a byte and offers it on valid/ready. Alternate glyphs via SEG7_ALT_GLYPHS_EN.
module seg7_pattern_rx
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
)
(
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [6:0] HEX0_in,
  input  logic [6:0] HEX1_in,
  input  logic       out_ready,
  output logic [7:0] value,
  output logic       out_valid,
  output logic       err,
  output logic       busy
);

  localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [13:0] BLANK_PAIR = {SEG_BLANK, SEG_BLANK};

  logic [13:0] sync_q [SYNC_STAGES];
  logic [13:0] s;
  logic [13:0] prev;
  logic [13:0] last_acc, last_acc_n;
  logic [7:0]  count, count_n;
  logic [7:0]  value_n;
  logic        out_valid_n;
  logic        err_n;
  logic [3:0]  lo_nib, hi_nib;
  logic        lo_legal, hi_legal;
  state_t      state, state_n;

  // Synchronizer chain plus a one-cycle delayed copy used for stability detection.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= BLANK_PAIR;
      prev <= BLANK_PAIR;
    end else begin
      sync_q[0] <= {HEX1_in, HEX0_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= s;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  seg7_glyph_decode u_dec_lo (.pattern(s[6:0]),  .nibble(lo_nib), .legal(lo_legal));
  seg7_glyph_decode u_dec_hi (.pattern(s[13:7]), .nibble(hi_nib), .legal(hi_legal));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 8'd0;
      value     <= 8'h00;
      out_valid <= 1'b0;
      err       <= 1'b0;
      last_acc  <= BLANK_PAIR;
    end else begin
      state     <= state_n;
      count     <= count_n;
      value     <= value_n;
      out_valid <= out_valid_n;
      err       <= err_n;
      last_acc  <= last_acc_n;
    end
  end

  // A pattern that settles back onto the last accepted one is dropped, never re-emitted.
  always_comb begin
    state_n     = state;
    count_n     = count;
    value_n     = value;
    out_valid_n = out_valid;
    err_n       = err;
    last_acc_n  = last_acc;
    case (state)
      IDLE: begin
        if (s != last_acc) begin
          state_n = SETTLE;
          count_n = 8'd1;
        end
      end
      SETTLE: begin
        if (s != prev) begin
          count_n = 8'd1;
        end else if (count >= STABLE_MAX) begin
          if (s == last_acc) begin
            state_n = IDLE;
          end else if (lo_legal && hi_legal) begin
            value_n     = {hi_nib, lo_nib};
            last_acc_n  = s;
            out_valid_n = 1'b1;
            state_n     = EMIT;
          end else begin
            err_n      = 1'b1;
            last_acc_n = s;
            state_n    = IDLE;
          end
        end else begin
          count_n = count + 8'd1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_seg7_pattern_rx.sv
// Directed self-checking bench for seg7_pattern_rx (default parameters STABLE_CYCLES=4, SYNC_STAGES=2).
module tb_seg7_pattern_rx;

  logic       CLOCK_50;
  logic       reset;
  logic [6:0] HEX0_in;
  logic [6:0] HEX1_in;
  logic       out_ready;
  logic [7:0] value;
  logic       out_valid;
  logic       err;
  logic       busy;

  int testsRun  = 0;
  int testsFail = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_pattern_rx dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .HEX0_in  (HEX0_in),
    .HEX1_in  (HEX1_in),
    .out_ready(out_ready),
    .value    (value),
    .out_valid(out_valid),
    .err      (err),
    .busy     (busy)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge, well away from the sampling edge.
  task automatic applyStimulus(input logic [6:0] h1, input logic [6:0] h0, input logic rdy);
    @(negedge CLOCK_50);
    HEX1_in   = h1;
    HEX0_in   = h0;
    out_ready = rdy;
  endtask

  task automatic waitValid(input int maxCycles, output int cycles);
    cycles = -1;
    for (int i = 1; i <= maxCycles; i++) begin
      @(negedge CLOCK_50);
      if (out_valid) begin
        cycles = i;
        return;
      end
    end
  endtask

  task automatic countValids(input int n, output int hits, output logic [7:0] lastVal);
    hits    = 0;
    lastVal = 8'hXX;
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      if (out_valid) begin
        hits++;
        lastVal = value;
      end
    end
  endtask

  initial begin
    int         cyc;
    int         hits;
    int         good;
    logic [7:0] lv;

    reset     = 1'b1;
    HEX1_in   = 7'h7F;
    HEX0_in   = 7'h7F;
    out_ready = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checkOutput("rst_value", 32'(value), 32'h00);
    checkOutput("rst_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;

    // Latency and single-cycle emission with ready held high
    applyStimulus(7'h79, 7'h08, 1'b1);
    waitValid(20, cyc);
    checkOutput("latency", 32'(cyc), 32'd7);
    checkOutput("value_1A", 32'(value), 32'h1A);
    checkOutput("err_1A", 32'(err), 32'h0);
    @(negedge CLOCK_50);
    checkOutput("one_cycle", 32'(out_valid), 32'h0);

    // Every glyph in both positions
    for (int i = 0; i < 16; i++) begin
      applyStimulus(glyph[15-i], glyph[i], 1'b1);
      waitValid(20, cyc);
      checkOutput($sformatf("sweep_%0d", i), {23'd0, out_valid, value},
                  {23'd0, 1'b1, 4'(15 - i), 4'(i)});
    end

    // Toggling faster than the stability window never emits
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(7'h79, (i % 2 == 0) ? 7'h40 : 7'h79, 1'b1);
      @(negedge CLOCK_50);
      if (out_valid) hits++;
      if (i > 0 && out_valid) hits++;
    end
    checkOutput("toggle_none", 32'(hits), 32'd0);
    applyStimulus(7'h79, 7'h79, 1'b1);
    countValids(30, hits, lv);
    checkOutput("hold_once", 32'(hits), 32'd1);
    checkOutput("hold_value", 32'(lv), 32'h11);

    // Back-pressure: value held while input changes underneath
    applyStimulus(7'h0E, 7'h00, 1'b0);
    waitValid(20, cyc);
    checkOutput("f8_valid", 32'(out_valid), 32'h1);
    good = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLOCK_50);
      if (out_valid && value == 8'hF8 && busy) good++;
      if (k == 20) begin
        HEX1_in = 7'h40;
        HEX0_in = 7'h40;
      end
    end
    checkOutput("f8_held", 32'(good), 32'd50);
    applyStimulus(7'h40, 7'h40, 1'b1);
    @(negedge CLOCK_50);
    checkOutput("f8_accepted", 32'(out_valid), 32'h0);
    waitValid(20, cyc);
    checkOutput("value_00", {23'd0, out_valid, value}, {23'd0, 1'b1, 8'h00});

    // Blank digit is illegal and sets the sticky error
    applyStimulus(7'h40, 7'h7F, 1'b1);
    countValids(20, hits, lv);
    checkOutput("blank_none", 32'(hits), 32'd0);
    checkOutput("blank_err", 32'(err), 32'h1);
    checkOutput("blank_idle", 32'(busy), 32'h0);
    applyStimulus(7'h24, 7'h30, 1'b1);
    waitValid(20, cyc);
    checkOutput("after_err", {23'd0, out_valid, value}, {23'd0, 1'b1, 8'h23});
    checkOutput("err_sticky", 32'(err), 32'h1);

    // Reset while settling at count 3
    applyStimulus(7'h12, 7'h19, 1'b1);
    repeat (5) @(negedge CLOCK_50);
    checkOutput("settling", 32'(busy), 32'h1);
    reset   = 1'b1;
    HEX1_in = 7'h7F;
    HEX0_in = 7'h7F;
    @(negedge CLOCK_50);
    checkOutput("midrst_valid", 32'(out_valid), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_err", 32'(err), 32'h0);
    reset = 1'b0;
    countValids(20, hits, lv);
    checkOutput("midrst_none", 32'(hits), 32'd0);

    // Alternate 7 and 9 drawings
    applyStimulus(7'h58, 7'h18, 1'b1);
    countValids(20, hits, lv);
`ifdef SEG7_ALT_GLYPHS_EN
    checkOutput("alt_hits", 32'(hits), 32'd1);
    checkOutput("alt_value", 32'(lv), 32'h79);
    checkOutput("alt_err", 32'(err), 32'h0);
`else
    checkOutput("alt_hits", 32'(hits), 32'd0);
    checkOutput("alt_err", 32'(err), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
